dly_chain4: RTL and testbench

- Four-stage timing-chain sequencer for the 50 MHz (20 ns/tick) emulation clock.
- One counter is shared across four consecutive delay stages, each with its own programmed length.
- Emits one-clock pulses at each stage end, as a hardware timing chain does (e.g. memory cycle: read-pulse, strobe, write, done).
- Supports an external hold at selected stage boundaries, abort, and back-to-back restart. Replaces ad-hoc cascades of individual delay instances in cycle control logic.

---
 rtl/dly_pkg.sv | 15 +
 rtl/dly_chain4_if.sv | 24 ++
 rtl/dly_chain4_stage_ctr.sv | 40 ++++
 rtl/dly_chain4.sv | 146 ++++++++++++++
 tb/tb_dly_chain4.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dly_pkg.sv
// Shared definitions for the timing-chain sequencer family.
package dly_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam int unsigned TICK_NS    = 20;
    localparam int unsigned NUM_STAGES = 4;
    localparam int unsigned STAGE_W    = 2;
    localparam int unsigned LAST_STAGE = NUM_STAGES - 1;

endpackage

// File: rtl/dly_chain4_if.sv
// Control/status bundle of the four-stage timing chain.
interface dly_chain4_if;
    import dly_pkg::*;

    logic                  start;
    logic                  hold;
    logic                  abort;
    logic [NUM_STAGES-1:0] p;
    logic                  l;
    logic [STAGE_W-1:0]    stage;
    logic                  waiting;
    logic                  err;

    modport master (
        output start, hold, abort,
        input  p, l, stage, waiting, err
    );

    modport slave (
        input  start, hold, abort,
        output p, l, stage, waiting, err
    );

endinterface

// File: rtl/dly_chain4_stage_ctr.sv
// Shared stage counter: clear, load-1 or increment, with an equality-to-limit flag.
module dly_stage_ctr
    import dly_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         match_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = W'(1);
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_c = (cnt_q == limit);

endmodule

// File: rtl/dly_chain4.sv
// Four-stage timing-chain sequencer: one shared counter, one-cycle pulse at each stage end,
// optional hold at selected boundaries, abort and back-to-back restart.
module dly_chain4
    import dly_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned D0       = 5,
    parameter int unsigned D1       = 10,
    parameter int unsigned D2       = 15,
    parameter int unsigned D3       = 25,
    parameter logic [3:0]  HOLDMASK = 4'b0000
) (
    input  logic         clk,
    input  logic         reset,
    dly_chain4_if.slave  bus
);

    localparam logic [63:0] D_MAX = (64'(1) << W) - 64'(1);

    if (D0 == 0 || D1 == 0 || D2 == 0 || D3 == 0 ||
        64'(D0) > D_MAX || 64'(D1) > D_MAX || 64'(D2) > D_MAX || 64'(D3) > D_MAX) begin : g_bad_len
        $error("dly_chain4: every stage length must lie in 1..2^W-1");
    end

    state_e             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               err_q, err_d;

    logic               ctr_clr, ctr_load, ctr_inc;
    logic               match_c;
    logic [W-1:0]       limit_c;
    logic               run_match;
    logic               last_stage;

    // Limit of the stage currently being timed
    always_comb begin
        case (stage_q)
            2'd0:    limit_c = W'(D0);
            2'd1:    limit_c = W'(D1);
            2'd2:    limit_c = W'(D2);
            default: limit_c = W'(D3);
        endcase
    end

    dly_stage_ctr #(.W(W)) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .clr     (ctr_clr),
        .load    (ctr_load),
        .inc     (ctr_inc),
        .limit   (limit_c),
        .match_c (match_c)
    );

    assign run_match  = (state_q == ST_RUN) && match_c;
    assign last_stage = (stage_q == STAGE_W'(LAST_STAGE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            err_q   <= err_d;
        end
    end

    // Next state: abort beats a restart, which beats the normal advance
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        err_d    = 1'b0;
        ctr_clr  = 1'b0;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_RUN;
                    stage_d  = '0;
                    ctr_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    stage_d = '0;
                    ctr_clr = 1'b1;
                    err_d   = bus.start;
                end else if (run_match && last_stage) begin
                    stage_d = '0;
                    if (bus.start) begin
                        ctr_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        ctr_clr = 1'b1;
                    end
                end else begin
                    err_d = bus.start;
                    if (run_match) begin
                        if (HOLDMASK[stage_q] && bus.hold) begin
                            state_d = ST_WAIT;
                        end else begin
                            stage_d  = stage_q + STAGE_W'(1);
                            ctr_load = 1'b1;
                        end
                    end else begin
                        ctr_inc = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                err_d = bus.start;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    stage_d = '0;
                    ctr_clr = 1'b1;
                end else if (!bus.hold) begin
                    state_d  = ST_RUN;
                    stage_d  = stage_q + STAGE_W'(1);
                    ctr_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                stage_d = '0;
                ctr_clr = 1'b1;
            end
        endcase
    end

    // Outputs decoded from registers
    always_comb begin
        bus.p = '0;
        if (run_match) begin
            bus.p[stage_q] = 1'b1;
        end
        bus.l       = (state_q != ST_IDLE);
        bus.waiting = (state_q == ST_WAIT);
        bus.stage   = stage_q;
        bus.err     = err_q;
    end

endmodule

// File: tb/tb_dly_chain4.sv
// Bench for dly_chain4: directed scenarios plus random traffic against a deadline-based model.
module tb_dly_chain4;

    localparam logic [3:0] HM = 4'b1010;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    dly_chain4_if bus_if ();

    dly_chain4 #(
        .W(8), .D0(5), .D1(10), .D2(15), .D3(25), .HOLDMASK(HM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;

    // Model: chain is either idle or counting toward an absolute deadline cycle
    bit m_busy, m_wait, m_err;
    int m_stg, m_due;

    int n_pulse [4];
    int last_pulse [4];
    int l_cyc, w_cyc, w_first, w_last, e_cyc, e_first;

    function automatic int dlen(input int s);
        case (s)
            0:       return 5;
            1:       return 10;
            2:       return 15;
            default: return 25;
        endcase
    endfunction

    function automatic logic [3:0] exp_p();
        if (m_busy && !m_wait && cyc == m_due) return 4'(1) << m_stg;
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d rel=%0d observed=%0h expected=%0h", tag, cyc, cyc - base, obs, exp);
        end
    endtask

    task automatic model_idle();
        m_busy = 1'b0;
        m_wait = 1'b0;
        m_stg  = 0;
    endtask

    task automatic check_cycle();
        logic [3:0] ep;
        int rel;
        ep  = exp_p();
        rel = cyc - base;
        chk("p",       32'(bus_if.p),       32'(ep));
        chk("l",       32'(bus_if.l),       32'(m_busy));
        chk("stage",   32'(bus_if.stage),   32'(m_stg));
        chk("waiting", 32'(bus_if.waiting), 32'(m_wait));
        chk("err",     32'(bus_if.err),     32'(m_err));
        for (int i = 0; i < 4; i++) begin
            if (bus_if.p[i] === 1'b1) begin
                n_pulse[i]++;
                last_pulse[i] = rel;
            end
        end
        if (bus_if.l === 1'b1) l_cyc++;
        if (bus_if.waiting === 1'b1) begin
            if (w_cyc == 0) w_first = rel;
            w_last = rel;
            w_cyc++;
        end
        if (bus_if.err === 1'b1) begin
            if (e_cyc == 0) e_first = rel;
            e_cyc++;
        end
    endtask

    task automatic model_next(input logic st, input logic hd, input logic ab);
        logic [3:0] ep;
        bit nerr;
        ep   = exp_p();
        nerr = m_busy && st && (ab || !ep[3]);
        if (!m_busy) begin
            if (st) begin
                m_busy = 1'b1;
                m_wait = 1'b0;
                m_stg  = 0;
                m_due  = cyc + dlen(0);
            end
        end else if (ab) begin
            model_idle();
        end else if (ep[3] && st) begin
            m_stg = 0;
            m_due = cyc + dlen(0);
        end else if (m_wait) begin
            if (!hd) begin
                m_wait = 1'b0;
                m_stg++;
                m_due = cyc + dlen(m_stg);
            end
        end else if (ep != 4'b0000) begin
            if (m_stg == 3) begin
                model_idle();
            end else if (HM[m_stg] && hd) begin
                m_wait = 1'b1;
            end else begin
                m_stg++;
                m_due = cyc + dlen(m_stg);
            end
        end
        m_err = nerr;
    endtask

    task automatic step(input logic st, input logic hd, input logic ab);
        bus_if.start = st;
        bus_if.hold  = hd;
        bus_if.abort = ab;
        @(negedge clk);
        check_cycle();
        model_next(st, hd, ab);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n, input logic hd);
        repeat (n) step(1'b0, hd, 1'b0);
    endtask

    task automatic begin_scn();
        base = cyc;
        for (int i = 0; i < 4; i++) begin
            n_pulse[i]    = 0;
            last_pulse[i] = -1;
        end
        l_cyc = 0; w_cyc = 0; w_first = -1; w_last = -1; e_cyc = 0; e_first = -1;
    endtask

    initial begin
        logic h;
        bus_if.start = 1'b0;
        bus_if.hold  = 1'b0;
        bus_if.abort = 1'b0;
        model_idle();
        m_err = 1'b0;
        m_due = 0;

        // Reset state
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;

        // A: plain run with defaults
        begin_scn();
        step(1'b1, 1'b0, 1'b0);
        run(60, 1'b0);
        chk("A_p0_at", 32'(last_pulse[0]), 32'd5);
        chk("A_p1_at", 32'(last_pulse[1]), 32'd15);
        chk("A_p2_at", 32'(last_pulse[2]), 32'd30);
        chk("A_p3_at", 32'(last_pulse[3]), 32'd55);
        chk("A_l_cycles", 32'(l_cyc), 32'd55);
        chk("A_err_cycles", 32'(e_cyc), 32'd0);

        // B: hold at the stage-1 boundary
        begin_scn();
        step(1'b1, 1'b0, 1'b0);
        run(9, 1'b0);
        run(30, 1'b1);
        run(51, 1'b0);
        chk("B_p1_at", 32'(last_pulse[1]), 32'd15);
        chk("B_p2_at", 32'(last_pulse[2]), 32'd55);
        chk("B_p3_at", 32'(last_pulse[3]), 32'd80);
        chk("B_wait_first", 32'(w_first), 32'd16);
        chk("B_wait_last", 32'(w_last), 32'd40);
        chk("B_wait_cycles", 32'(w_cyc), 32'd25);
        chk("B_l_cycles", 32'(l_cyc), 32'd80);

        // C: abort at rel 20
        begin_scn();
        step(1'b1, 1'b0, 1'b0);
        run(19, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        run(40, 1'b0);
        chk("C_p0_count", 32'(n_pulse[0]), 32'd1);
        chk("C_p1_count", 32'(n_pulse[1]), 32'd1);
        chk("C_late_pulses", 32'(n_pulse[2] + n_pulse[3]), 32'd0);
        chk("C_l_cycles", 32'(l_cyc), 32'd20);

        // D: rejected start while busy
        begin_scn();
        step(1'b1, 1'b0, 1'b0);
        run(9, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run(50, 1'b0);
        chk("D_err_cycles", 32'(e_cyc), 32'd1);
        chk("D_err_at", 32'(e_first), 32'd11);
        chk("D_p3_at", 32'(last_pulse[3]), 32'd55);
        chk("D_l_cycles", 32'(l_cyc), 32'd55);

        // E: restart coincident with p3
        begin_scn();
        step(1'b1, 1'b0, 1'b0);
        run(54, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run(60, 1'b0);
        chk("E_p0_count", 32'(n_pulse[0]), 32'd2);
        chk("E_p0_at", 32'(last_pulse[0]), 32'd60);
        chk("E_p3_at", 32'(last_pulse[3]), 32'd110);
        chk("E_l_cycles", 32'(l_cyc), 32'd110);
        chk("E_err_cycles", 32'(e_cyc), 32'd0);

        // F: asynchronous reset mid-chain, then a fresh start
        begin_scn();
        step(1'b1, 1'b0, 1'b0);
        run(11, 1'b0);
        bus_if.start = 1'b0;
        bus_if.hold  = 1'b0;
        bus_if.abort = 1'b0;
        @(negedge clk);
        check_cycle();
        #2;
        reset = 1'b1;
        #1;
        chk("F_l_async", 32'(bus_if.l), 32'd0);
        chk("F_p_async", 32'(bus_if.p), 32'd0);
        chk("F_wait_async", 32'(bus_if.waiting), 32'd0);
        chk("F_stage_async", 32'(bus_if.stage), 32'd0);
        model_idle();
        m_err = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
        run(7, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run(10, 1'b0);
        chk("F_p0_count", 32'(n_pulse[0]), 32'd2);
        chk("F_p0_at", 32'(last_pulse[0]), 32'd25);
        chk("F_p1_count", 32'(n_pulse[1]), 32'd0);
        chk("F_l_cycles", 32'(l_cyc), 32'd22);

        // R: random start/hold/abort traffic against the model
        begin_scn();
        h = 1'b0;
        repeat (1500) begin
            if ($urandom_range(0, 9) == 0) h = ~h;
            step(1'($urandom_range(0, 24) == 0), h, 1'($urandom_range(0, 79) == 0));
        end
        run(120, 1'b0);
        chk("R_idle_at_end", 32'(bus_if.l), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
